// File: rtl/sar_search_if.sv
// sar_search_if: request/result bundle between sar_search and its comparator side.
// trial_eq exists only when SAR_SEARCH_EARLY_EN is defined.
interface sar_search_if #(
    parameter int W = 4
);
    logic         start;
    logic         trial_gt;
`ifdef SAR_SEARCH_EARLY_EN
    logic         trial_eq;
`endif
    logic [W-1:0] trial;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

`ifdef SAR_SEARCH_EARLY_EN
    modport master (
        input  start,
        input  trial_gt,
        input  trial_eq,
        output trial,
        output busy,
        output done,
        output result
    );

    modport slave (
        output start,
        output trial_gt,
        output trial_eq,
        input  trial,
        input  busy,
        input  done,
        input  result
    );
`else
    modport master (
        input  start,
        input  trial_gt,
        output trial,
        output busy,
        output done,
        output result
    );

    modport slave (
        output start,
        output trial_gt,
        input  trial,
        input  busy,
        input  done,
        input  result
    );
`endif
endinterface

// File: rtl/sar_search.sv
// sar_search: MSB-first successive-approximation controller driving an external comparator.
// SAR_SEARCH_EARLY_EN enables trial_eq and an early exit on an exact match.
//
//   state  | meaning
//   IDLE   | waiting for start, trial/result held
//   TEST   | one trial bit resolved per cycle, busy high
//   DONE   | one-cycle done pulse, result valid
module sar_search #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    sar_search_if.master sar_if
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TEST = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  trial_q, trial_d;
    logic [W-1:0]  result_q, result_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  idx_mask;
    logic [W-1:0]  next_trial;
    logic          eq_hit;

    always_comb begin
        idx_mask   = W'(1) << idx_q;
        next_trial = sar_if.trial_gt ? (trial_q & ~idx_mask) : trial_q;
`ifdef SAR_SEARCH_EARLY_EN
        eq_hit     = sar_if.trial_eq;
`else
        eq_hit     = 1'b0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        result_d = result_q;
        idx_d    = idx_q;
        case (state_q)
            S_IDLE: begin
                if (sar_if.start) begin
                    trial_d = W'(1) << (W - 1);
                    idx_d   = IW'(W - 1);
                    state_d = S_TEST;
                end
            end
            S_TEST: begin
                // exact match outranks the greater-than answer
                if (eq_hit) begin
                    result_d = trial_q;
                    state_d  = S_DONE;
                end else if (idx_q != '0) begin
                    trial_d = next_trial | (idx_mask >> 1);
                    idx_d   = idx_q - IW'(1);
                end else begin
                    result_d = next_trial;
                    trial_d  = next_trial;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            trial_q  <= '0;
            result_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            idx_q    <= idx_d;
        end
    end

    assign sar_if.trial  = trial_q;
    assign sar_if.busy   = (state_q == S_TEST);
    assign sar_if.done   = (state_q == S_DONE);
    assign sar_if.result = result_q;
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: randomized and directed checks of sar_search against a bit-by-bit search model.
// Build with or without SAR_SEARCH_EARLY_EN; the model follows the same define.
module tb_sar_search;
    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic [W-1:0] target = '0;

    int total = 0;
    int bad   = 0;

    int           obs_trials[$];
    int           exp_trials[$];
    int           exp_res;
    int           busy_cnt;
    int           done_cnt;
    int           done_lat;
    logic [W-1:0] res_at_done;
    int           nd;
    int           last_done;
    int           tgt;

    sar_search_if #(.W(W)) bus ();

    assign bus.trial_gt = (bus.trial > target);
`ifdef SAR_SEARCH_EARLY_EN
    assign bus.trial_eq = (bus.trial == target);
`endif

    sar_search #(.W(W)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .sar_if  (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // Reference: try each bit from the MSB down, keep it unless the trial overshoots.
    function automatic void model(input int t);
        int acc;
        int tr;
        acc = 0;
        exp_trials.delete();
        for (int b = W - 1; b >= 0; b--) begin
            tr = acc | (1 << b);
            exp_trials.push_back(tr);
`ifdef SAR_SEARCH_EARLY_EN
            if (tr == t) begin
                exp_res = t;
                return;
            end
`endif
            if (!(tr > t)) acc = tr;
        end
        exp_res = acc;
    endfunction

    // Launch one search and watch W+4 cycles; optional stray start pulses in TEST and DONE.
    task automatic run_search(input int t, input bit pulses);
        int cyc;
        target = W'(t);
        obs_trials.delete();
        busy_cnt = 0;
        done_cnt = 0;
        done_lat = 0;
        res_at_done = '0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc = 1;
        repeat (W + 4) begin
            @(negedge clk);
            if (bus.busy) begin
                busy_cnt++;
                obs_trials.push_back(int'(bus.trial));
            end
            if (bus.done) begin
                done_cnt++;
                if (done_lat == 0) done_lat = cyc;
                res_at_done = bus.result;
            end
            if (pulses && ((bus.busy && cyc == 2) || bus.done)) bus.start = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
            cyc++;
        end
    endtask

    task automatic check_run(input string tag, input int t);
        model(t);
        check($sformatf("%s t=%0d ntrials", tag, t), obs_trials.size(), exp_trials.size());
        foreach (exp_trials[i])
            if (i < obs_trials.size())
                check($sformatf("%s t=%0d trial[%0d]", tag, t, i), obs_trials[i], exp_trials[i]);
        check($sformatf("%s t=%0d busy_cycles", tag, t), busy_cnt, exp_trials.size());
        check($sformatf("%s t=%0d done_pulses", tag, t), done_cnt, 1);
        check($sformatf("%s t=%0d done_latency", tag, t), done_lat, exp_trials.size() + 1);
        check($sformatf("%s t=%0d result_model", tag, t), res_at_done, exp_res);
        check($sformatf("%s t=%0d result_eq_target", tag, t), res_at_done, t);
        check($sformatf("%s t=%0d result_held", tag, t), bus.result, t);
        check($sformatf("%s t=%0d idle_after", tag, t), bus.busy, 0);
    endtask

    task automatic check_seq(input string tag, input int q[$]);
        check({tag, " nseq"}, obs_trials.size(), q.size());
        foreach (q[i])
            if (i < obs_trials.size())
                check($sformatf("%s seq[%0d]", tag, i), obs_trials[i], q[i]);
    endtask

    initial begin
        bus.start = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset trial", bus.trial, 0);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset result", bus.result, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_search(11, 1'b0);
        check_run("dir", 11);
        check_seq("t11", '{8, 12, 10, 11});
        run_search(0, 1'b0);
        check_run("dir", 0);
        check_seq("t0", '{8, 4, 2, 1});
        run_search(15, 1'b0);
        check_run("dir", 15);
        check_seq("t15", '{8, 12, 14, 15});
        run_search(5, 1'b0);
        check_run("dir", 5);
        check_seq("t5", '{8, 4, 6, 5});
        run_search(8, 1'b0);
        check_run("dir", 8);
`ifdef SAR_SEARCH_EARLY_EN
        check_seq("t8", '{8});
        check("t8 latency", done_lat, 2);
`else
        check_seq("t8", '{8, 12, 10, 9});
        check("t8 latency", done_lat, 5);
`endif

        for (int v = 0; v <= MAXV; v++) begin
            run_search(v, 1'b0);
            check_run("sweep", v);
        end

        for (int k = 0; k < 20; k++) begin
            tgt = int'($urandom_range(0, MAXV));
            run_search(tgt, bit'($urandom_range(0, 1)));
            check_run("rand", tgt);
        end

        run_search(13, 1'b1);
        check_run("stray_start", 13);

        // abort during the second TEST cycle
        target = W'(6);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        check("rst_mid busy_before", bus.busy, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mid trial", bus.trial, 0);
        check("rst_mid busy", bus.busy, 0);
        check("rst_mid done", bus.done, 0);
        check("rst_mid result", bus.result, 0);
        nd = 0;
        repeat (W + 3) begin
            @(negedge clk);
            if (bus.done || bus.busy) nd++;
        end
        check("rst_mid no_activity", nd, 0);
        run_search(6, 1'b0);
        check_run("after_rst", 6);

        // reset and start together
        @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        check("rst_start busy", bus.busy, 0);
        check("rst_start trial", bus.trial, 0);
        check("rst_start done", bus.done, 0);
        reset = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_start idle", bus.busy, 0);

        // start held high: a new search every trials+2 cycles
        target = W'(9);
        model(9);
        nd = 0;
        last_done = -1;
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) begin
                if (last_done >= 0)
                    check("b2b interval", c - last_done, exp_trials.size() + 2);
                check("b2b result", bus.result, 9);
                last_done = c;
                nd++;
            end
        end
        bus.start = 1'b0;
        check("b2b enough_dones", (nd >= 5), 1);
        repeat (W + 4) @(negedge clk);
        check("b2b drained", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
